param_updown_mod_counter: RTL
=============================

Name: param_updown_mod_counter

Overview:
Parametrised successor to the team's fixed 4-bit down counter with synchronous set. The block is a modulo-N up/down counter with:
- count enable
- synchronous set and synchronous parallel load
- selectable wrap or saturate mode
- terminal-count and wrap indicators

It serves as the general counter primitive for timers, dividers and sequencers across the design.

Parameters:
WIDTH, 4, counter register width in bits; legal range 1..32.
MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2^WIDTH.
SET_VALUE, MODULUS-1, value forced by S; must be < MODULUS.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
C  input  1  clock; all state changes on its rising edge except reset.
RN  input  1  reset.
S  input  1  synchronous set; Q <= SET_VALUE.
L  input  1  synchronous load; Q <= D, clamped.
D  input  WIDTH  load data.
CE  input  1  count enable.
UP  input  1  direction; 1 = increment, 0 = decrement.
Q  output  WIDTH  current count, registered.
TC  output  1  terminal count, combinational.
WRAP  output  1  registered one-cycle pulse marking a wrap.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. C is the clock. RN is the reset.
- RN low: Q = 0 and WRAP = 0 immediately, independent of C. Both hold while RN is low.
- RN deassertion: the first count is taken at the first rising edge of C with RN high. RN is synchronised externally.
- Priority at each rising edge of C, highest first:
  1. S: Q <= SET_VALUE; WRAP <= 0.
  2. L: if D < MODULUS, Q <= D; otherwise Q <= MODULUS-1. WRAP <= 0.
  3. CE with UP=1:
     - Q < MODULUS-1: Q <= Q+1.
     - Q = MODULUS-1, SATURATE=0: Q <= 0; WRAP <= 1.
     - Q = MODULUS-1, SATURATE=1: Q holds; WRAP <= 0.
  4. CE with UP=0:
     - Q > 0: Q <= Q-1.
     - Q = 0, SATURATE=0: Q <= MODULUS-1; WRAP <= 1.
     - Q = 0, SATURATE=1: Q holds; WRAP <= 0.
  5. Otherwise: Q holds; WRAP <= 0.
- S and L act regardless of CE. S beats L when both are asserted in the same cycle.
- WRAP is high for exactly one cycle following each wrap edge. It never asserts when SATURATE=1.
- TC = CE & ((UP & Q == MODULUS-1) | (~UP & Q == 0)).
  - TC is combinational from Q, CE and UP, with no register.
  - TC is intended for cascading into the next stage's CE.
  - TC asserts in saturate mode as well.
- Width rules:
  - All comparisons are unsigned.
  - When MODULUS = 2^WIDTH, wrap is the natural modular roll-over; the design needs no extra compare.
  - MODULUS-1 is computed at elaboration with width WIDTH.
- Direction change: UP may change on any cycle. The new direction applies at the next edge; no state is kept about the previous direction.
- Reset mid-operation: asserting RN during a count, set or load aborts it. Q = 0 and WRAP = 0 on the next settle, with no glitch to any other value.
- Illegal parameters (MODULUS < 2, MODULUS > 2^WIDTH, SET_VALUE >= MODULUS): the design must fail elaboration through a generate-time check.

Test Plan:
1. Wrap up (WIDTH=4, MODULUS=10, SATURATE=0). Release RN, hold CE=1, UP=1 for 12 cycles.
   -> Q sequence 0,1,…,9,0,1.
   -> TC high while Q=9.
   -> WRAP high exactly in the cycle Q=0 after the 9.
2. Wrap down (same configuration, UP=0 from Q=0).
   -> Q sequence 9,8,…,0,9.
   -> WRAP pulses after each 0→9 transition.
   -> TC high while Q=0.
3. Saturate (SATURATE=1, MODULUS=10). Count up 15 cycles.
   -> Q stops at 9 and holds; TC stays high; WRAP never asserts.
   Then set UP=0 and count down 12 cycles.
   -> Q reaches 0 and holds.
4. Priority and clamping (MODULUS=10, SET_VALUE=9, CE=1).
   - Assert S and L together with D=3 -> Q=9.
   - L alone with D=5 -> Q=5.
   - L with D=13 -> Q=9 (clamped).
   - CE=0 for 3 cycles -> Q holds at 9.
5. Async reset mid-count (MODULUS=16). Count up to 7, then drop RN between clock edges.
   -> Q=0 and WRAP=0 before the next edge of C.
   -> Q stays 0 while RN is low.
   -> Counting resumes 1,2,… after release.
6. Cascade (two instances, MODULUS=10). Connect TC of the low instance to CE of the high instance; run 25 counts up.
   -> {high, low} = 2,5.
   -> The high instance increments only on the edges where low goes 9→0.

Source files
------------

// File: rtl/param_updown_mod_counter_if.sv
// Bus bundle for param_updown_mod_counter.
//   S, L, D, CE, UP : control and load data from the user to the counter
//   Q, TC, WRAP     : count value and status from the counter to the user
// No valid/ready handshake is involved. Every control input is sampled
// at each rising clock edge, and the counter has no back-pressure.
interface param_updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             S;
  logic             L;
  logic [WIDTH-1:0] D;
  logic             CE;
  logic             UP;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             WRAP;

  modport master (
    output S, L, D, CE, UP,
    input  Q, TC, WRAP
  );

  modport slave (
    input  S, L, D, CE, UP,
    output Q, TC, WRAP
  );
endinterface

// File: rtl/param_updown_mod_counter.sv
// Modulo-MODULUS up/down counter. It counts over the range 0..MODULUS-1 and
// provides a synchronous set, a clamped parallel load, and a wrap or
// saturate mode.
// Ports:
//   C        rising-edge clock
//   RN       asynchronous active-low reset (Q = 0, WRAP = 0)
//   bus.S    synchronous set to SET_VALUE (highest priority)
//   bus.L    synchronous load of bus.D, clamped to MODULUS-1
//   bus.CE   count enable
//   bus.UP   direction (1 = up, 0 = down)
//   bus.Q    registered count
//   bus.TC   combinational terminal count, intended for the next stage's CE
//   bus.WRAP registered one-cycle pulse after each wrap
module param_updown_mod_counter #(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MODULUS   = 16,
  parameter longint unsigned SET_VALUE = MODULUS - 1,
  parameter bit              SATURATE  = 1'b0
) (
  input logic                       C,
  input logic                       RN,
  param_updown_mod_counter_if.slave bus
);

  // Illegal parameter sets abort elaboration. The upper bound uses 64-bit
  // arithmetic so that WIDTH = 32 with MODULUS = 2^32 is accepted.
  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        MODULUS > (64'd1 << WIDTH) || SET_VALUE >= MODULUS) begin : g_bad_params
      $fatal(1, "param_updown_mod_counter: illegal WIDTH/MODULUS/SET_VALUE");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] SET_VAL = WIDTH'(SET_VALUE);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;

  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.S) begin
      q_d = SET_VAL;
    end else if (bus.L) begin
      // Out-of-range load data is clamped. When MODULUS = 2^WIDTH, every
      // D passes this test.
      q_d = (64'(bus.D) < MODULUS) ? bus.D : MAX_VAL;
    end else if (bus.CE) begin
      if (bus.UP) begin
        if (!at_max) begin
          q_d = q_q + WIDTH'(1);
        end else if (!SATURATE) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_d = q_q - WIDTH'(1);
        end else if (!SATURATE) begin
          q_d    = MAX_VAL;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.WRAP = wrap_q;
  // TC is unregistered so that a cascaded stage sees it in the same cycle.
  assign bus.TC   = bus.CE & ((bus.UP & at_max) | (~bus.UP & at_zero));

endmodule
